// File: rtl/fb_mem_arbiter_if.sv
// Bus bundle between the framebuffer arbiter and its neighbours: scan-out
// timing, two writer ports, the clear engine controls and the RAM port.
interface fb_mem_arbiter_if #(
    parameter int AW = 17,
    parameter int DW = 4
);
    logic          valid;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          req0;
    logic          req1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          clr_start;
    logic [DW-1:0] clr_value;
    logic          clr_busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid;

    modport slave (
        input  valid, h_cnt, v_cnt,
        input  req0, req1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1,
        input  clr_start, clr_value,
        output clr_busy,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output pix_data, pix_valid
    );

    modport master (
        output valid, h_cnt, v_cnt,
        output req0, req1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1,
        output clr_start, clr_value,
        input  clr_busy,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  pix_data, pix_valid
    );
endinterface

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer arbiter: even active-video columns read for scan-out,
// every other cycle goes to the frame-clear engine or the two round-robin writers.
module fb_mem_arbiter #(
    parameter int FB_W = 320,
    parameter int FB_H = 240,
    parameter int AW   = 17,
    parameter int DW   = 4
) (
    input  logic             pclk,
    input  logic             reset,
    fb_mem_arbiter_if.slave  bus
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FB_W * FB_H - 1);

    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

    clr_state_t    state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [DW-1:0] clr_val_q, clr_val_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          rr_q, rr_d;
    logic          disp_p0_q, disp_p0_d;
    logic          disp_p1_q, disp_p1_d;
    logic          vld_p0_q, vld_p0_d;
    logic          vld_p1_q, vld_p1_d;
    logic          pix_valid_q, pix_valid_d;
    logic [DW-1:0] pix_data_q, pix_data_d;

    logic          disp_slot;
    logic [AW-1:0] disp_addr;
    logic          elig0, elig1, pick1;

    // Each framebuffer word covers a 2x2 block of display pixels.
    assign disp_slot = bus.valid && !bus.h_cnt[0];
    assign disp_addr = AW'(bus.v_cnt >> 1) * AW'(FB_W) + AW'(bus.h_cnt >> 1);

    // A request still high during its own grant cycle is the one just served.
    assign elig0 = bus.req0 && !gnt0_q;
    assign elig1 = bus.req1 && !gnt1_q;
    assign pick1 = elig1 && (!elig0 || rr_q);

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_val_d   = clr_val_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rr_d        = rr_q;
        pix_data_d  = pix_data_q;

        // Read pipeline: address out, RAM latency, capture into pix_data.
        disp_p0_d   = disp_slot;
        disp_p1_d   = disp_p0_q;
        vld_p0_d    = bus.valid;
        vld_p1_d    = vld_p0_q;
        pix_valid_d = vld_p1_q;
        if (disp_p1_q) begin
            pix_data_d = bus.mem_rdata;
        end

        if (disp_slot) begin
            mem_addr_d = disp_addr;
        end else if (state_q == CLR_RUN) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = clr_cnt_q;
            mem_wdata_d = clr_val_q;
            clr_cnt_d   = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
                state_d = CLR_IDLE;
            end
        end else if (!bus.clr_start && (elig0 || elig1)) begin
            mem_we_d = 1'b1;
            if (pick1) begin
                mem_addr_d  = bus.addr1;
                mem_wdata_d = bus.wdata1;
                gnt1_d      = 1'b1;
                rr_d        = 1'b0;
            end else begin
                mem_addr_d  = bus.addr0;
                mem_wdata_d = bus.wdata0;
                gnt0_d      = 1'b1;
                rr_d        = 1'b1;
            end
        end

        if (state_q == CLR_IDLE && bus.clr_start) begin
            state_d   = CLR_RUN;
            clr_cnt_d = '0;
            clr_val_d = bus.clr_value;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= CLR_IDLE;
            clr_cnt_q   <= '0;
            clr_val_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rr_q        <= 1'b0;
            disp_p0_q   <= 1'b0;
            disp_p1_q   <= 1'b0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_val_q   <= clr_val_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rr_q        <= rr_d;
            disp_p0_q   <= disp_p0_d;
            disp_p1_q   <= disp_p1_d;
            vld_p0_q    <= vld_p0_d;
            vld_p1_q    <= vld_p1_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.clr_busy  = (state_q == CLR_RUN);
    assign bus.pix_data  = pix_data_q;
    assign bus.pix_valid = pix_valid_q;
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Randomized bench for fb_mem_arbiter: a RAM model sits on the memory port and a
// frame-level reference predicts every bus cycle, grant and pixel.
module tb_fb_mem_arbiter;
    localparam int FB_W   = 320;
    localparam int FB_H   = 240;
    localparam int AW     = 17;
    localparam int DW     = 4;
    localparam int NWORDS = FB_W * FB_H;

    logic pclk  = 1'b0;
    logic reset = 1'b1;

    fb_mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

    fb_mem_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .AW(AW), .DW(DW)) dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;

    // Synchronous single-port RAM, read-before-write.
    bit [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge pclk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: framebuffer contents plus clear progress and writer fairness.
    bit [DW-1:0] shadow [0:(1<<AW)-1];
    bit          m_clearing;
    int          m_cnt;
    bit [DW-1:0] m_fill;
    int          m_pref;
    bit          m_g0, m_g1;
    int          e_we, e_addr, e_wdata, e_g0, e_g1, e_busy, e_pix, e_pixv;
    bit          p_disp [2];
    bit          p_vld  [2];
    bit [DW-1:0] p_val  [2];

    int en0 = 0, en1 = 0, wp = 100;

    task automatic model_step();
        bit disp, was_clr, el0, el1;
        int win, da;
        bit [DW-1:0] rd;
        if (reset) begin
            e_we = 0; e_addr = 0; e_wdata = 0; e_g0 = 0; e_g1 = 0;
            e_busy = 0; e_pix = 0; e_pixv = 0;
            m_clearing = 0; m_cnt = 0; m_pref = 0; m_g0 = 0; m_g1 = 0;
            for (int i = 0; i < 2; i++) begin
                p_disp[i] = 0; p_vld[i] = 0; p_val[i] = '0;
            end
        end else begin
            // What leaves the pixel port after this edge was read two slots ago.
            e_pixv = int'(p_vld[1]);
            if (p_disp[1]) e_pix = int'(p_val[1]);
            disp = bus.valid && (int'(bus.h_cnt) % 2 == 0);
            da   = (int'(bus.v_cnt) / 2) * FB_W + int'(bus.h_cnt) / 2;
            rd   = disp ? shadow[da] : '0;
            p_disp[1] = p_disp[0]; p_vld[1] = p_vld[0]; p_val[1] = p_val[0];
            p_disp[0] = disp;      p_vld[0] = bus.valid; p_val[0] = rd;

            was_clr = m_clearing;
            e_we = 0; e_g0 = 0; e_g1 = 0;
            if (disp) begin
                e_addr = da;
            end else if (was_clr) begin
                e_we = 1; e_addr = m_cnt; e_wdata = int'(m_fill);
                shadow[m_cnt] = m_fill;
                m_cnt++;
                if (m_cnt == NWORDS) m_clearing = 0;
            end else if (!bus.clr_start) begin
                el0 = bus.req0 && !m_g0;
                el1 = bus.req1 && !m_g1;
                if (el0 && el1) win = m_pref;
                else if (el0)   win = 0;
                else if (el1)   win = 1;
                else            win = -1;
                if (win == 0) begin
                    e_we = 1; e_addr = int'(bus.addr0); e_wdata = int'(bus.wdata0);
                    shadow[bus.addr0] = bus.wdata0; e_g0 = 1; m_pref = 1;
                end else if (win == 1) begin
                    e_we = 1; e_addr = int'(bus.addr1); e_wdata = int'(bus.wdata1);
                    shadow[bus.addr1] = bus.wdata1; e_g1 = 1; m_pref = 0;
                end
            end
            if (!was_clr && bus.clr_start) begin
                m_clearing = 1; m_cnt = 0; m_fill = bus.clr_value;
            end
            m_g0 = (e_g0 != 0); m_g1 = (e_g1 != 0);
            e_busy = int'(m_clearing);
        end
    endtask

    task automatic compare();
        check_eq("mem_we",    32'(bus.mem_we),    32'(e_we));
        check_eq("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
        if (e_we != 0) check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
        check_eq("gnt0",      32'(bus.gnt0),      32'(e_g0));
        check_eq("gnt1",      32'(bus.gnt1),      32'(e_g1));
        check_eq("clr_busy",  32'(bus.clr_busy),  32'(e_busy));
        check_eq("pix_valid", 32'(bus.pix_valid), 32'(e_pixv));
        check_eq("pix_data",  32'(bus.pix_data),  32'(e_pix));
    endtask

    task automatic new_req0();
        bus.req0 = 1'b1; bus.addr0 = AW'($urandom_range(NWORDS - 1)); bus.wdata0 = DW'($urandom);
    endtask

    task automatic new_req1();
        bus.req1 = 1'b1; bus.addr1 = AW'($urandom_range(NWORDS - 1)); bus.wdata1 = DW'($urandom);
    endtask

    // Writers hold a request until granted, then drop it or post a new one.
    task automatic writers_update();
        if (bus.gnt0) begin
            if (en0 != 0 && $urandom_range(1) == 1) new_req0(); else bus.req0 = 1'b0;
        end else if (!bus.req0 && en0 != 0 && $urandom_range(99) < wp) new_req0();
        if (bus.gnt1) begin
            if (en1 != 0 && $urandom_range(1) == 1) new_req1(); else bus.req1 = 1'b0;
        end else if (!bus.req1 && en1 != 0 && $urandom_range(99) < wp) new_req1();
    endtask

    task automatic tick();
        model_step();
        @(posedge pclk);
        #1;
        compare();
        bus.clr_start = 1'b0;
        writers_update();
    endtask

    task automatic scan(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) begin
            bus.valid = 1'b1; bus.h_cnt = 10'(h); bus.v_cnt = 10'(v);
            tick();
        end
        bus.valid = 1'b0;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) begin
            bus.valid = 1'b0; bus.h_cnt = 10'($urandom_range(1023)); bus.v_cnt = 10'($urandom_range(1023));
            tick();
        end
    endtask

    initial begin
        int guard, bad, hs;
        bus.valid = 1'b0; bus.h_cnt = '0; bus.v_cnt = '0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0; bus.clr_start = 1'b0; bus.clr_value = '0;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Plain scan-out, corner addresses included.
        scan(0, 0, 5);     blank(4);
        scan(2, 0, 3);     blank(3);
        scan(479, 634, 639); blank(5);

        // Writer 0 hammering during active video.
        en0 = 1; wp = 100;
        scan(10, 0, 39);
        en0 = 0;
        blank(4);

        // Both writers contending in blanking.
        en0 = 1; en1 = 1;
        blank(40);
        en0 = 0; en1 = 0;
        blank(4);

        // Mixed random traffic.
        en0 = 1; en1 = 1; wp = 40;
        for (int i = 0; i < 60; i++) begin
            hs = $urandom_range(600);
            scan($urandom_range(479), hs, hs + $urandom_range(39));
            blank($urandom_range(1, 12));
        end

        // Clear interrupted by reset.
        wp = 30;
        bus.clr_value = DW'($urandom); bus.clr_start = 1'b1;
        blank(500);
        scan(100, 0, 19);
        blank(490);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        blank(2);

        // Clear racing a writer-1 request, run to completion.
        if (!bus.req1) new_req1();
        en1 = 1;
        bus.clr_value = 4'hA; bus.clr_start = 1'b1;
        tick();
        guard = 0;
        while (bus.clr_busy && guard < 80000) begin
            if (guard == 300) scan(200, 0, 39); else tick();
            guard++;
        end
        check_eq("clear_finished_in_budget", 32'(guard < 80000), 32'd1);
        en0 = 0; en1 = 0;
        blank(6);

        bad = 0;
        for (int a = 0; a < NWORDS; a++) if (ram[a] != shadow[a]) bad++;
        check_eq("ram_contents", 32'(bad), 32'd0);

        scan(0, 0, 39);
        scan(479, 600, 639);
        blank(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
